// File: rtl/issue_arbiter.sv
// issue_arbiter: round-robin issue onto 2 ALUs, MUL and MEM; `define ISSUE_ARB_STATS_EN for stall counters
module issue_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int MUL_LAT = 3,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_fu,
  input  logic                 flush,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 alu0_valid,
  output logic                 alu1_valid,
  output logic [IDX_W-1:0]     alu0_idx,
  output logic [IDX_W-1:0]     alu1_idx,
  output logic                 mul_busy,
  output logic                 mul_done_valid,
  output logic [IDX_W-1:0]     mul_done_idx,
  output logic                 mem_req_valid,
  output logic [IDX_W-1:0]     mem_req_idx,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
`ifdef ISSUE_ARB_STATS_EN
  output logic [31:0]          stall_alu,
  output logic [31:0]          stall_mul,
  output logic [31:0]          stall_mem,
`endif
  output logic                 mem_done_valid,
  output logic [IDX_W-1:0]     mem_done_idx
);
  localparam int CW = $clog2(MUL_LAT + 1);
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT} mem_st_t;
  mem_st_t mem_st, mem_st_n;
  logic [IDX_W-1:0] ptr_alu, ptr_mul, ptr_mem;
  logic [NUM_REQ-1:0] is_alu, is_mul, is_mem;
  logic a0_f, a1_f, m_f, e_f;
  logic [IDX_W-1:0] a0_i, a1_i, m_i, e_i;
  logic g_a0, g_a1, g_m, g_e;
  logic [CW-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] mul_idx, mem_idx;
  logic mem_done_q, mem_done_n;
  function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] p, input int k);
    return p + IDX_W'(k);
  endfunction
  always_comb begin
    is_alu = '0;
    is_mul = '0;
    is_mem = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      is_alu[j] = req_valid[j] && req_fu[2*j +: 2] == 2'd0;
      is_mul[j] = req_valid[j] && req_fu[2*j +: 2] == 2'd1;
      is_mem[j] = req_valid[j] && req_fu[2*j +: 2] == 2'd2;
    end
  end
  always_comb begin
    a0_f = 1'b0;
    a1_f = 1'b0;
    a0_i = '0;
    a1_i = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (is_alu[rot(ptr_alu, k)]) begin
        if (!a0_f) begin
          a0_f = 1'b1;
          a0_i = rot(ptr_alu, k);
        end else if (!a1_f) begin
          a1_f = 1'b1;
          a1_i = rot(ptr_alu, k);
        end
      end
    end
  end
  always_comb begin
    m_f = 1'b0;
    m_i = '0;
    e_f = 1'b0;
    e_i = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!m_f && is_mul[rot(ptr_mul, k)]) begin
        m_f = 1'b1;
        m_i = rot(ptr_mul, k);
      end
      if (!e_f && is_mem[rot(ptr_mem, k)]) begin
        e_f = 1'b1;
        e_i = rot(ptr_mem, k);
      end
    end
  end
  assign g_a0 = a0_f && !flush;
  assign g_a1 = a1_f && !flush;
  assign g_m  = m_f && !flush && cnt <= CW'(1);
  assign g_e  = e_f && !flush && mem_st == M_IDLE;
  always_comb begin
    grant = '0;
    grant = (g_a0 ? NUM_REQ'(1) << a0_i : '0) | (g_a1 ? NUM_REQ'(1) << a1_i : '0)
          | (g_m ? NUM_REQ'(1) << m_i : '0) | (g_e ? NUM_REQ'(1) << e_i : '0);
  end
  always_comb begin
    cnt_n = flush ? '0 : g_m ? CW'(MUL_LAT) : cnt != '0 ? cnt - CW'(1) : '0;
  end
  always_comb begin
    mem_st_n = mem_st;
    mem_st_n = flush ? M_IDLE
             : (mem_st == M_IDLE && g_e) ? M_REQ
             : (mem_st == M_REQ && mem_req_ready) ? M_WAIT
             : (mem_st == M_WAIT && mem_resp_valid) ? M_IDLE : mem_st;
    mem_done_n = mem_st == M_WAIT && mem_resp_valid && !flush;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_alu    <= '0;
      ptr_mul    <= '0;
      ptr_mem    <= '0;
      alu0_valid <= 1'b0;
      alu1_valid <= 1'b0;
      alu0_idx   <= '0;
      alu1_idx   <= '0;
      cnt        <= '0;
      mul_idx    <= '0;
      mem_st     <= M_IDLE;
      mem_idx    <= '0;
      mem_done_q <= 1'b0;
    end else begin
      ptr_alu    <= g_a1 ? a1_i + IDX_W'(1) : g_a0 ? a0_i + IDX_W'(1) : ptr_alu;
      ptr_mul    <= g_m ? m_i + IDX_W'(1) : ptr_mul;
      ptr_mem    <= g_e ? e_i + IDX_W'(1) : ptr_mem;
      alu0_valid <= g_a0;
      alu1_valid <= g_a1;
      alu0_idx   <= g_a0 ? a0_i : '0;
      alu1_idx   <= g_a1 ? a1_i : '0;
      cnt        <= cnt_n;
      mul_idx    <= g_m ? m_i : mul_idx;
      mem_st     <= mem_st_n;
      mem_idx    <= g_e ? e_i : mem_idx;
      mem_done_q <= mem_done_n;
    end
  end
  assign mul_busy       = cnt != '0;
  assign mul_done_valid = cnt == CW'(1) && !flush;
  assign mul_done_idx   = mul_idx;
  assign mem_req_valid  = mem_st == M_REQ;
  assign mem_req_idx    = mem_idx;
  assign mem_done_valid = mem_done_q && !flush;
  assign mem_done_idx   = mem_idx;
`ifdef ISSUE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_alu <= '0;
      stall_mul <= '0;
      stall_mem <= '0;
    end else begin
      stall_alu <= (|is_alu && !g_a0 && stall_alu != '1) ? stall_alu + 32'd1 : stall_alu;
      stall_mul <= (|is_mul && !g_m && stall_mul != '1) ? stall_mul + 32'd1 : stall_mul;
      stall_mem <= (|is_mem && !g_e && stall_mem != '1) ? stall_mem + 32'd1 : stall_mem;
    end
  end
`endif
endmodule

// File: tb/tb_issue_arbiter.sv
// tb_issue_arbiter: directed test-plan steps plus random traffic against a queue-based reference model
module tb_issue_arbiter;
  localparam int N = 8;
  localparam int L = 3;
  localparam int W = 3;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [2*N-1:0] req_fu = '0;
  logic flush = 1'b0;
  logic mem_req_ready = 1'b0;
  logic mem_resp_valid = 1'b0;
  logic [N-1:0] grant;
  logic alu0_valid, alu1_valid, mul_busy, mul_done_valid, mem_req_valid, mem_done_valid;
  logic [W-1:0] alu0_idx, alu1_idx, mul_done_idx, mem_req_idx, mem_done_idx;
  always #5 clk = ~clk;
  issue_arbiter #(.NUM_REQ(N), .MUL_LAT(L)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_fu(req_fu), .flush(flush),
    .grant(grant), .alu0_valid(alu0_valid), .alu1_valid(alu1_valid),
    .alu0_idx(alu0_idx), .alu1_idx(alu1_idx), .mul_busy(mul_busy),
    .mul_done_valid(mul_done_valid), .mul_done_idx(mul_done_idx),
    .mem_req_valid(mem_req_valid), .mem_req_idx(mem_req_idx),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_done_valid(mem_done_valid), .mem_done_idx(mem_done_idx)
  );
  int vectors = 0;
  int errs = 0;
  int pa, pm, pe, mul_rem, mul_i, mem_st, mem_i, a0i, a1i, gm, ge;
  bit pend, a0v, a1v;
  int ga[$];
  logic [N-1:0] eg;
  task automatic model_reset();
    pa = 0; pm = 0; pe = 0; mul_rem = 0; mul_i = 0; mem_st = 0; mem_i = 0;
    pend = 0; a0v = 0; a1v = 0; a0i = 0; a1i = 0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int cls(input int i);
    return req_valid[i] ? int'(req_fu[2*i +: 2]) : -1;
  endfunction
  task automatic predict();
    ga.delete();
    gm = -1;
    ge = -1;
    for (int k = 0; k < N; k++) begin
      if (cls((pa + k) % N) == 0 && ga.size() < 2) ga.push_back((pa + k) % N);
      if (cls((pm + k) % N) == 1 && gm < 0) gm = (pm + k) % N;
      if (cls((pe + k) % N) == 2 && ge < 0) ge = (pe + k) % N;
    end
    if (flush) ga.delete();
    if (flush || mul_rem > 1) gm = -1;
    if (flush || mem_st != 0) ge = -1;
    eg = '0;
    foreach (ga[j]) eg[ga[j]] = 1'b1;
    if (gm >= 0) eg[gm] = 1'b1;
    if (ge >= 0) eg[ge] = 1'b1;
  endtask
  task automatic check_all();
    predict();
    chk("grant", grant, eg);
    chk("alu0_valid", alu0_valid, a0v);
    if (a0v) chk("alu0_idx", alu0_idx, a0i);
    chk("alu1_valid", alu1_valid, a1v);
    if (a1v) chk("alu1_idx", alu1_idx, a1i);
    chk("mul_busy", mul_busy, mul_rem > 0);
    chk("mul_done_valid", mul_done_valid, mul_rem == 1 && !flush);
    if (mul_rem == 1 && !flush) chk("mul_done_idx", mul_done_idx, mul_i);
    chk("mem_req_valid", mem_req_valid, mem_st == 1);
    if (mem_st == 1) chk("mem_req_idx", mem_req_idx, mem_i);
    chk("mem_done_valid", mem_done_valid, pend && !flush);
    if (pend && !flush) chk("mem_done_idx", mem_done_idx, mem_i);
  endtask
  task automatic update();
    bit np;
    a0v = ga.size() > 0;
    a1v = ga.size() > 1;
    a0i = a0v ? ga[0] : 0;
    a1i = a1v ? ga[1] : 0;
    if (ga.size() > 0) pa = (ga[ga.size()-1] + 1) % N;
    if (gm >= 0) pm = (gm + 1) % N;
    if (ge >= 0) pe = (ge + 1) % N;
    np = mem_st == 2 && mem_resp_valid && !flush;
    if (flush) mul_rem = 0;
    else if (gm >= 0) begin mul_rem = L; mul_i = gm; end
    else if (mul_rem > 0) mul_rem--;
    if (flush) mem_st = 0;
    else if (mem_st == 0 && ge >= 0) begin mem_st = 1; mem_i = ge; end
    else if (mem_st == 1 && mem_req_ready) mem_st = 2;
    else if (mem_st == 2 && mem_resp_valid) mem_st = 0;
    pend = np;
  endtask
  task automatic cycle();
    #3 check_all();
    @(posedge clk);
    #1 update();
  endtask
  initial begin
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1 rstn = 1'b1;
    req_valid = 8'hFF; req_fu = '0;
    #1 chk("tp_alu_grant0", grant, 8'h03);
    cycle();
    chk("tp_alu0_idx", alu0_idx, 0);
    chk("tp_alu1_idx", alu1_idx, 1);
    #1 chk("tp_alu_grant1", grant, 8'h0C);
    cycle();
    req_valid = 8'h40;
    cycle();
    req_valid = 8'h81;
    #1 chk("tp_wrap_grant", grant, 8'h81);
    cycle();
    chk("tp_wrap_alu0", alu0_idx, 7);
    chk("tp_wrap_alu1", alu1_idx, 0);
    req_valid = 8'hFF;
    #1 chk("tp_wrap_ptr", grant, 8'h06);
    cycle();
    req_valid = '0;
    cycle();
    req_valid = 8'h28; req_fu = 16'h0440;
    #1 chk("tp_mul_grant", grant, 8'h08);
    cycle();
    req_valid = 8'h20;
    cycle();
    cycle();
    #1 chk("tp_mul_done", mul_done_valid, 1);
    chk("tp_mul_done_idx", mul_done_idx, 3);
    chk("tp_mul_b2b", grant, 8'h20);
    cycle();
    req_valid = '0;
    repeat (4) cycle();
    req_valid = 8'h40; req_fu = 16'h2000;
    #1 chk("tp_mem_grant", grant, 8'h40);
    cycle();
    req_valid = 8'h02; req_fu = 16'h0008;
    repeat (4) begin
      #1 chk("tp_mem_req", mem_req_valid, 1);
      chk("tp_mem_idx", mem_req_idx, 6);
      chk("tp_mem_hold", grant, 0);
      cycle();
    end
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0;
    repeat (2) cycle();
    mem_resp_valid = 1'b1;
    cycle();
    mem_resp_valid = 1'b0;
    #1 chk("tp_mem_done", mem_done_valid, 1);
    chk("tp_mem_done_idx", mem_done_idx, 6);
    chk("tp_mem_next", grant, 8'h02);
    cycle();
    req_valid = '0;
    repeat (3) cycle();
    req_valid = 8'h14; req_fu = 16'h0210; mem_req_ready = 1'b1;
    cycle();
    req_valid = '0;
    cycle();
    mem_req_ready = 1'b0;
    flush = 1'b1; mem_resp_valid = 1'b1; req_valid = 8'hFF; req_fu = '0;
    #1 chk("tp_flush_grant", grant, 0);
    cycle();
    flush = 1'b0; mem_resp_valid = 1'b0; req_valid = '0;
    #1 chk("tp_flush_mul", mul_busy, 0);
    chk("tp_flush_mem", mem_req_valid, 0);
    repeat (4) cycle();
    req_valid = 8'h03; req_fu = 16'h0004;
    cycle();
    req_valid = '0;
    #2 rstn = 1'b0;
    #1 chk("tp_rst_mul", mul_busy, 0);
    chk("tp_rst_alu", alu0_valid, 0);
    chk("tp_rst_done", mul_done_valid, 0);
    chk("tp_rst_grant", grant, 0);
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) cycle();
    repeat (2000) begin
      req_valid = N'($urandom);
      req_fu = (2*N)'($urandom);
      flush = $urandom_range(15) == 0;
      mem_req_ready = $urandom_range(1);
      mem_resp_valid = $urandom_range(2) == 0;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
